// File: rtl/jtframe_clkmon.sv
// Frequency monitor for a slow clock sampled as data on clk: counts clk_in rising
// edges per WIN-cycle window and judges range. Optional hysteresis: JTFRAME_CLKMON_HYST_EN.
module jtframe_clkmon #(
   parameter int unsigned WIN     = 1024,
   parameter int unsigned SETTLE  = 64,
   parameter int unsigned CW      = 12,
   parameter int unsigned EXP_MIN = 62,
   parameter int unsigned EXP_MAX = 66
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          locked,
   input  logic          clk_in,
   output logic [CW-1:0] freq,
   output logic          freq_valid,
   output logic          ok,
   output logic          lost,
   output logic [7:0]    err_cnt
);

   localparam logic [15:0] WIN_LAST = 16'(WIN - 1);
   localparam logic [15:0] SET_LAST = (SETTLE == 0) ? 16'd0 : 16'(SETTLE - 1);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_SETTLE,
      ST_MEASURE
   } state_t;

   state_t          r_state;
   state_t          w_state_nxt;

   logic            r_lock_s1, r_lock_s2;
   logic            r_cin_s1, r_cin_s2, r_cin_s3;
   logic [15:0]     r_set_cnt;
   logic [15:0]     r_win_cnt;
   logic [CW-1:0]   r_edge_cnt;
   logic [CW-1:0]   r_freq;
   logic            r_valid;
   logic            r_ok;
   logic            r_ok_q;
   logic            r_lost;
   logic [7:0]      r_err;
`ifdef JTFRAME_CLKMON_HYST_EN
   logic            r_good;
`endif

   logic            w_lock;
   logic            w_edge;
   logic            w_set_last;
   logic            w_win_last;
   logic [CW-1:0]   w_edge_sum;
   logic            w_in_rng;
   logic [7:0]      w_err_inc;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_lock_s1 <= 1'b0;
         r_lock_s2 <= 1'b0;
         r_cin_s1  <= 1'b0;
         r_cin_s2  <= 1'b0;
         r_cin_s3  <= 1'b0;
      end else begin
         r_lock_s1 <= locked;
         r_lock_s2 <= r_lock_s1;
         r_cin_s1  <= clk_in;
         r_cin_s2  <= r_cin_s1;
         r_cin_s3  <= r_cin_s2;
      end
   end

   assign w_lock     = r_lock_s2;
   assign w_edge     = r_cin_s2 & ~r_cin_s3;
   assign w_set_last = (r_set_cnt == SET_LAST);
   assign w_win_last = (r_win_cnt == WIN_LAST);
   // The terminal-cycle edge is folded in here so it lands in the closing window
   assign w_edge_sum = (w_edge && (r_edge_cnt != '1)) ? r_edge_cnt + 1'b1 : r_edge_cnt;
   assign w_in_rng   = (w_edge_sum >= CW'(EXP_MIN)) && (w_edge_sum <= CW'(EXP_MAX));
   assign w_err_inc  = (r_err != '1) ? r_err + 8'd1 : r_err;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      if (!w_lock) begin
         w_state_nxt = ST_IDLE;
      end else begin
         case (r_state)
            ST_IDLE:    w_state_nxt = ST_SETTLE;
            ST_SETTLE:  if (w_set_last) w_state_nxt = ST_MEASURE;
            ST_MEASURE: w_state_nxt = ST_MEASURE;
            default:    w_state_nxt = ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_set_cnt  <= '0;
         r_win_cnt  <= '0;
         r_edge_cnt <= '0;
         r_freq     <= '0;
         r_valid    <= 1'b0;
         r_ok       <= 1'b0;
         r_ok_q     <= 1'b0;
         r_lost     <= 1'b0;
         r_err      <= '0;
`ifdef JTFRAME_CLKMON_HYST_EN
         r_good     <= 1'b0;
`endif
      end else begin
         r_valid <= 1'b0;
         r_ok_q  <= r_ok;
         r_lost  <= r_ok_q & ~r_ok;
         if (!w_lock) begin
            r_set_cnt  <= '0;
            r_win_cnt  <= '0;
            r_edge_cnt <= '0;
            r_ok       <= 1'b0;
`ifdef JTFRAME_CLKMON_HYST_EN
            r_good     <= 1'b0;
`endif
         end else begin
            case (r_state)
               ST_SETTLE: begin
                  r_set_cnt  <= w_set_last ? '0 : r_set_cnt + 16'd1;
                  r_win_cnt  <= '0;
                  r_edge_cnt <= '0;
               end
               ST_MEASURE: begin
                  if (w_win_last) begin
                     r_freq     <= w_edge_sum;
                     r_valid    <= 1'b1;
                     r_win_cnt  <= '0;
                     r_edge_cnt <= '0;
`ifdef JTFRAME_CLKMON_HYST_EN
                     if (w_in_rng) begin
                        if (r_good) r_ok <= 1'b1;
                        r_good <= 1'b1;
                     end else begin
                        r_ok   <= 1'b0;
                        r_good <= 1'b0;
                        r_err  <= w_err_inc;
                     end
`else
                     if (w_in_rng) begin
                        r_ok  <= 1'b1;
                     end else begin
                        r_ok  <= 1'b0;
                        r_err <= w_err_inc;
                     end
`endif
                  end else begin
                     r_win_cnt  <= r_win_cnt + 16'd1;
                     r_edge_cnt <= w_edge_sum;
                  end
               end
               default: begin
                  r_set_cnt  <= '0;
                  r_win_cnt  <= '0;
                  r_edge_cnt <= '0;
               end
            endcase
         end
      end
   end

   assign freq       = r_freq;
   assign freq_valid = r_valid;
   assign ok         = r_ok;
   assign lost       = r_lost;
   assign err_cnt    = r_err;

endmodule

// File: doc/jtframe_clkmon.md
JTFRAME_CLKMON -- requirements
Module: jtframe_clkmon

Interface
- REQ-001 SHALL have parameter WIN, default 1024: measurement window length in clk cycles, range 16..65535.
- REQ-002 SHALL have parameter SETTLE, default 64: clk cycles waited after lock before the first window.
- REQ-003 SHALL have parameter CW, default 12: width of the edge counter and freq.
- REQ-004 SHALL have parameter EXP_MIN, default 62: lowest in-range edge count per window.
- REQ-005 SHALL have parameter EXP_MAX, default 66: highest in-range edge count per window.
- REQ-006 SHALL have port clk, input, 1 bit: single clock for all logic; posedge only.
- REQ-007 SHALL have port rst_n, input, 1 bit: reset, asynchronous, active-low.
- REQ-008 SHALL have port locked, input, 1 bit: asynchronous PLL lock flag.
- REQ-009 SHALL have port clk_in, input, 1 bit: monitored clock, sampled as data; frequency below clk/4.
- REQ-010 SHALL have port freq, output, CW bits: edge count of the last completed window.
- REQ-011 SHALL have port freq_valid, output, 1 bit: one-cycle pulse when freq updates.
- REQ-012 SHALL have port ok, output, 1 bit: monitored clock judged in range.
- REQ-013 SHALL have port lost, output, 1 bit: one-cycle pulse on each ok 1->0 transition.
- REQ-014 SHALL have port err_cnt, output, 8 bits: count of out-of-range windows, saturating.

Function
- REQ-015 SHALL pass locked and clk_in through separate 2-flop synchronizers; a third flop on clk_in gives edge detect (sync2 & ~sync3).
- REQ-016 SHALL have exactly three states: IDLE, SETTLE, MEASURE.
- REQ-017 IDLE: edge and window counters held at 0; exits to SETTLE when synchronized locked = 1.
- REQ-018 SETTLE: counts SETTLE cycles; afterwards enters MEASURE with window and edge counters at 0.
- REQ-019 MEASURE: window counter increments every cycle; each detected edge increments the edge counter, saturating at 2^CW-1.
- REQ-020 Terminal cycle (window count = WIN-1): an edge detected in that cycle is counted in the current window.
- REQ-021 After the terminal cycle, the following cycle: freq = final count, freq_valid = 1 for exactly that cycle, and both counters restart at 0 with no cycle gap.
- REQ-022 Window result is in range when EXP_MIN <= count <= EXP_MAX, compared unsigned at CW bits.
- REQ-023 Out-of-range result: err_cnt increments, saturating at 255; ok clears in the same cycle freq_valid asserts.
- REQ-024 Synchronized locked = 0 in any state: next state IDLE, ok cleared, counters zeroed, freq and err_cnt retained.
- REQ-025 lost asserts in the cycle after ok falls, for any cause; it never asserts while ok stays 0.

Reset
- REQ-026 Asserting rst_n low SHALL immediately set IDLE state, all synchronizer flops to 0, counters to 0, freq = 0, freq_valid = 0, ok = 0, lost = 0, err_cnt = 0.
- REQ-027 Reset SHALL be honoured mid-window; after release, no freq_valid is issued until a full SETTLE plus WIN sequence completes.

Configuration
- REQ-028 With macro JTFRAME_CLKMON_HYST_EN defined: ok sets only after two consecutive in-range windows; one out-of-range window clears it, and a clear also resets the consecutive-window count.
- REQ-029 Without JTFRAME_CLKMON_HYST_EN: ok sets on the freq_valid of any single in-range window.

Verification
- REQ-030 Setup: clk 96 MHz, clk_in 6 MHz (16 clks per period), locked high after reset, default parameters -> first freq_valid at about SETTLE+WIN+4 cycles, freq = 64, ok = 1 (without HYST_EN).
- REQ-031 Same setup with HYST_EN -> ok = 0 after the first window and ok = 1 after the second window.
- REQ-032 clk_in changed to 4 MHz (24 clks per period) -> next freq within 42..43, ok falls, lost pulses once, err_cnt increments by 1 per window.
- REQ-033 locked dropped mid-window for 10 cycles -> state IDLE, ok = 0, lost pulses once, no freq_valid; measurement resumes after SETTLE+WIN cycles.
- REQ-034 rst_n asserted mid-window -> all outputs 0 immediately; clk_in held at constant 0 for 300 out-of-range windows -> freq = 0 each window, err_cnt saturates at 255.
- REQ-035 clk_in edge placed exactly on the terminal cycle -> counted in the current window, not the next.
